// File: rtl/int_ctrl_if.sv
// int_ctrl_if: request/service signal bundle between an interrupt source side and int_ctrl
//   in_IR   raw requests (rising edge requests service)   in_IG   per-channel pending clear
//   in_INM  per-channel mask (1 = masked)                 in_IE   global enable
//   in_ACK  CPU accepts presented interrupt               in_EOI  end of highest in-service
//   out_code presented channel index   out_break CPU request   out_pend/out_isr state registers
interface int_ctrl_if #(
   parameter int CODE_W = 2
);
   localparam int N_CH = 2 ** CODE_W;
   logic [N_CH-1:0]   in_IR;
   logic [N_CH-1:0]   in_IG;
   logic [N_CH-1:0]   in_INM;
   logic              in_IE;
   logic              in_ACK;
   logic              in_EOI;
   logic [CODE_W-1:0] out_code;
   logic              out_break;
   logic [N_CH-1:0]   out_pend;
   logic [N_CH-1:0]   out_isr;
   modport master (
      output in_IR, in_IG, in_INM, in_IE, in_ACK, in_EOI,
      input  out_code, out_break, out_pend, out_isr
   );
   modport slave (
      input  in_IR, in_IG, in_INM, in_IE, in_ACK, in_EOI,
      output out_code, out_break, out_pend, out_isr
   );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered priority interrupt controller with optional nesting
//   in_CLK   clock, all state changes on rising edge
//   in_RST_N asynchronous active-low reset
//   bus      int_ctrl_if slave: requests, clears, mask, enable, ACK/EOI in; code, break, pend, isr out
module int_ctrl #(
   parameter int CODE_W = 2,
   parameter int NEST   = 1
) (
   input logic       in_CLK,
   input logic       in_RST_N,
   int_ctrl_if.slave bus
);
   localparam int N_CH = 2 ** CODE_W;
   logic [N_CH-1:0]   ir_d, pend, isr, rise, elig, ack_set, eoi_clr;
   logic [CODE_W-1:0] code, isr_top;
   logic              preempt_ok, brk;
   assign rise = bus.in_IR & ~ir_d;
   assign elig = pend & ~bus.in_INM;
   // highest set index wins: later loop iterations overwrite lower ones
   always_comb begin
      code    = '0;
      isr_top = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (elig[i]) code = CODE_W'(i);
         if (isr[i]) isr_top = CODE_W'(i);
      end
   end
   assign preempt_ok = (isr == '0) || (NEST != 0 && code > isr_top);
   assign brk        = bus.in_IE && (elig != '0) && preempt_ok;
   assign ack_set    = (bus.in_ACK && brk) ? N_CH'(1) << code : '0;
   // EOI is judged against the pre-edge isr, so a same-edge ACK is never undone
   assign eoi_clr    = (bus.in_EOI && isr != '0) ? N_CH'(1) << isr_top : '0;
   always_ff @(posedge in_CLK or negedge in_RST_N) begin
      if (!in_RST_N) begin
         ir_d <= '0;
         pend <= '0;
         isr  <= '0;
      end else begin
         ir_d <= bus.in_IR;
         pend <= (pend & ~bus.in_IG & ~ack_set) | rise;
         isr  <= (isr & ~eoi_clr) | ack_set;
      end
   end
   assign bus.out_code  = code;
   assign bus.out_break = brk;
   assign bus.out_pend  = pend;
   assign bus.out_isr   = isr;
endmodule
